// File: rtl/function_unit_pkg.sv
// Shared types and constants for the sequential function unit.
// Opcode space, block decode and FSM states are used by the top and by fu_comb_core.
package function_unit_pkg;

    typedef enum logic [3:0] {
        FS_ADD   = 4'b0000,
        FS_ADDC  = 4'b0001,
        FS_PASSA = 4'b0010,
        FS_INCA  = 4'b0011,
        FS_NEGB  = 4'b0100,
        FS_NEGA  = 4'b0101,
        FS_SUB   = 4'b0110,
        FS_DECA  = 4'b0111,
        FS_AND   = 4'b1000,
        FS_NOTA  = 4'b1001,
        FS_NOTB  = 4'b1010,
        FS_OR    = 4'b1011,
        FS_MOD   = 4'b1100,
        FS_SHL   = 4'b1101,
        FS_SHR   = 4'b1110,
        FS_SRA   = 4'b1111
    } fs_e;

    // Block decode on fs[3:2]; the arithmetic block ignores fs[2].
    localparam logic [1:0] BLK_ARITH = 2'b00;
    localparam logic [1:0] BLK_LOGIC = 2'b10;
    localparam logic [1:0] BLK_SHIFT = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic logic is_arith(input logic [3:0] fs);
        return fs[3] == BLK_ARITH[1];
    endfunction

endpackage

// File: rtl/fu_comb_core.sv
// Combinational arithmetic/logic core: result plus overflow and carry.
// Shift-block opcodes produce zero here; the top owns the shift datapath.
module fu_comb_core
    import function_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [3:0]       fs,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_c,
    output logic             v_c,
    output logic             c_c
);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             cmsb;
    logic [WIDTH-1:0] lgc;

    // All arithmetic forms map onto x + y + cin.
    always_comb begin
        x   = a;
        y   = '0;
        cin = 1'b0;
        case (fs_e'(fs))
            FS_ADD:   y = b;
            FS_ADDC:  begin y = b; cin = 1'b1; end
            FS_PASSA: ;
            FS_INCA:  cin = 1'b1;
            FS_NEGB:  begin x = '0; y = ~b; cin = 1'b1; end
            FS_NEGA:  begin x = '0; y = ~a; cin = 1'b1; end
            FS_SUB:   begin y = ~b; cin = 1'b1; end
            FS_DECA:  y = '1;
            default:  ;
        endcase
    end

    assign sum  = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(cin);
    // Carry into the MSB recovered from the MSB sum bit.
    assign cmsb = sum[WIDTH-1] ^ x[WIDTH-1] ^ y[WIDTH-1];

    always_comb begin
        lgc = '0;
        case (fs[1:0])
            2'b00: lgc = a & b;
            2'b01: lgc = ~a;
            2'b10: lgc = ~b;
            2'b11: lgc = a | b;
            default: lgc = '0;
        endcase
    end

    always_comb begin
        res_c = '0;
        v_c   = 1'b0;
        c_c   = 1'b0;
        if (is_arith(fs)) begin
            res_c = sum[WIDTH-1:0];
            c_c   = sum[WIDTH];
            v_c   = cmsb ^ sum[WIDTH];
        end else if (fs[3:2] == BLK_LOGIC) begin
            res_c = lgc;
        end
    end

endmodule

// File: rtl/function_unit_seq.sv
// Registered function unit with valid/ready handshake and a one-bit-per-cycle shifter.
// Optional sticky overflow flag enabled by defining FUNCTION_UNIT_STICKY_V_EN.
module function_unit_seq
    import function_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       fs,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             v,
    output logic             c,
    output logic             n,
    output logic             z,
`ifdef FUNCTION_UNIT_STICKY_V_EN
    output logic             v_sticky,
    input  logic             v_clr,
`endif
    output logic             busy
);

    state_e           state;
    state_e           state_nx;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nx;
    logic [WIDTH-1:0] work_step;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   cnt_nx;
    logic [1:0]       kind;
    logic [1:0]       kind_nx;

    logic [WIDTH-1:0] res_nx;
    logic             v_nx;
    logic             c_nx;
    logic             n_nx;
    logic             z_nx;
    logic             out_valid_nx;
    logic             busy_nx;
    logic             done;

    logic [WIDTH-1:0] core_res;
    logic             core_v;
    logic             core_c;
    logic [SHW-1:0]   amt;
    logic             shift_blk;
    logic             iter_op;
    logic             accept;
    logic [WIDTH-1:0] direct_shift;

    fu_comb_core #(.WIDTH(WIDTH)) u_core (
        .fs    (fs),
        .a     (op_a),
        .b     (op_b),
        .res_c (core_res),
        .v_c   (core_v),
        .c_c   (core_c)
    );

    assign amt       = op_a[SHW-1:0];
    assign shift_blk = (fs[3:2] == BLK_SHIFT);
    // Only shifts by a nonzero amount need the iterative path; mod is single-cycle.
    assign iter_op   = shift_blk && (fs != 4'(FS_MOD)) && (amt != '0);
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    always_comb begin
        direct_shift = op_b;
        if (fs == 4'(FS_MOD)) begin
            direct_shift = op_b & ~({WIDTH{1'b1}} << amt);
        end
    end

    always_comb begin
        case (kind)
            2'b01:   work_step = {work[WIDTH-2:0], 1'b0};
            2'b10:   work_step = {1'b0, work[WIDTH-1:1]};
            default: work_step = {work[WIDTH-1], work[WIDTH-1:1]};
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && iter_op) state_nx = SHIFT;
            SHIFT:   if (cnt == SHW'(1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        done    = 1'b0;
        res_nx  = result;
        v_nx    = v;
        c_nx    = c;
        work_nx = work;
        cnt_nx  = cnt;
        kind_nx = kind;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (iter_op) begin
                        work_nx = op_b;
                        cnt_nx  = amt;
                        kind_nx = fs[1:0];
                    end else begin
                        done   = 1'b1;
                        res_nx = shift_blk ? direct_shift : core_res;
                        v_nx   = core_v;
                        c_nx   = core_c;
                    end
                end
            end
            SHIFT: begin
                work_nx = work_step;
                cnt_nx  = SHW'(cnt - SHW'(1));
                if (cnt == SHW'(1)) begin
                    done   = 1'b1;
                    res_nx = work_step;
                    v_nx   = 1'b0;
                    c_nx   = 1'b0;
                end
            end
            default: ;
        endcase
        n_nx         = res_nx[WIDTH-1];
        z_nx         = (res_nx == '0);
        // A completion in the same cycle as a drain replaces the old result.
        out_valid_nx = done || (out_valid && !out_ready);
        busy_nx      = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            v         <= 1'b0;
            c         <= 1'b0;
            n         <= 1'b0;
            z         <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            work      <= '0;
            cnt       <= '0;
            kind      <= '0;
        end else begin
            result    <= res_nx;
            v         <= v_nx;
            c         <= c_nx;
            n         <= n_nx;
            z         <= z_nx;
            out_valid <= out_valid_nx;
            busy      <= busy_nx;
            work      <= work_nx;
            cnt       <= cnt_nx;
            kind      <= kind_nx;
        end
    end

`ifdef FUNCTION_UNIT_STICKY_V_EN
    // Clear has priority over a simultaneous overflow completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_sticky <= 1'b0;
        end else if (v_clr) begin
            v_sticky <= 1'b0;
        end else if (done && v_nx) begin
            v_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_function_unit_seq.sv
// Scoreboard bench for function_unit_seq (WIDTH=8): directed vectors, latency,
// backpressure, mid-shift reset and, when FUNCTION_UNIT_STICKY_V_EN is defined, the sticky flag.
module tb_function_unit_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] fs;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       v, c, n, z;
    logic       busy;
`ifdef FUNCTION_UNIT_STICKY_V_EN
    logic       v_sticky;
    logic       v_clr;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] r;
        logic       v;
        logic       c;
        logic       n;
        logic       z;
        string      nm;
    } exp_t;

    exp_t sbq[$];

    function_unit_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fs        (fs),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .v         (v),
        .c         (c),
        .n         (n),
        .z         (z),
`ifdef FUNCTION_UNIT_STICKY_V_EN
        .v_sticky  (v_sticky),
        .v_clr     (v_clr),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Monitor: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got res=%h with empty scoreboard", result);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if ({result, v, c, n, z} !== {e.r, e.v, e.c, e.n, e.z}) begin
                    bad++;
                    $display("FAIL %s: got res=%h v=%b c=%b n=%b z=%b, want res=%h v=%b c=%b n=%b z=%b",
                             e.nm, result, v, c, n, z, e.r, e.v, e.c, e.n, e.z);
                end
            end
        end
    end

    task automatic push(input logic [7:0] er, input logic ev, input logic ec, input string nm);
        exp_t e;
        e.r  = er;
        e.v  = ev;
        e.c  = ec;
        e.n  = er[7];
        e.z  = (er == 8'h00);
        e.nm = nm;
        sbq.push_back(e);
    endtask

    // elat: edges after the accept edge until out_valid shows (0 = visible in the
    // cycle right after acceptance); -1 = fire and forget, nothing expected.
    task automatic issue(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic ev, input logic ec,
                         input int elat, input string nm);
        bit got;
        int lat;
        int bsy;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        fs       = f;
        op_a     = a;
        op_b     = b;
        got      = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk({nm, "_accept"}, 32'(got), 32'd1);
        if (elat >= 0) push(er, ev, ec, nm);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (elat >= 0) begin
            lat = 0;
            bsy = 0;
            while (lat < 40) begin
                @(negedge clk);
                if (out_valid) break;
                bsy += int'(busy);
                lat++;
            end
            chk({nm, "_lat"}, 32'(lat), 32'(elat));
            chk({nm, "_busy"}, 32'(bsy), 32'(elat));
        end
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        fs        = 4'h0;
        op_a      = 8'h00;
        op_b      = 8'h00;
        out_ready = 1'b1;
`ifdef FUNCTION_UNIT_STICKY_V_EN
        v_clr     = 1'b0;
`endif
        #3;
        chk("rst_outputs", 32'({result, v, c, n, z, out_valid, busy}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        //     fs     A      B      result v     c     lat name
        issue(4'h0, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 0, "add_ovf");
        issue(4'h6, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 0, "sub_zero");
        issue(4'h1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 0, "addc_wrap");
        issue(4'h4, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 0, "neg_b");
        issue(4'h5, 8'h80, 8'h00, 8'h80, 1'b1, 1'b0, 0, "neg_a_min");
        issue(4'h7, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 0, "dec_zero");
        issue(4'h3, 8'h7F, 8'h00, 8'h80, 1'b1, 1'b0, 0, "inc_ovf");
        issue(4'h2, 8'h3C, 8'h55, 8'h3C, 1'b0, 1'b0, 0, "pass_a");
        issue(4'h8, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 0, "and");
        issue(4'h9, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 0, "not_a");
        issue(4'hA, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 0, "not_b");
        issue(4'hF, 8'h03, 8'h90, 8'hF2, 1'b0, 1'b0, 3, "sra3");
        issue(4'hD, 8'h00, 8'h5A, 8'h5A, 1'b0, 1'b0, 0, "shl0");
        issue(4'hD, 8'h02, 8'hC3, 8'h0C, 1'b0, 1'b0, 2, "shl2");
        issue(4'hE, 8'h07, 8'h80, 8'h01, 1'b0, 1'b0, 7, "shr7");
        issue(4'hF, 8'h01, 8'h40, 8'h20, 1'b0, 1'b0, 1, "sra1");
        issue(4'hC, 8'h05, 8'hFF, 8'h1F, 1'b0, 1'b0, 0, "mod5");
        issue(4'hC, 8'h00, 8'hAB, 8'h00, 1'b0, 1'b0, 0, "mod0");

        // Backpressure: result held, no new accept until the consumer drains.
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(4'h0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 0, "bp_add");
        repeat (3) @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_valid_held", 32'(out_valid), 32'd1);
        chk("bp_result_held", 32'(result), 32'h03);
        // Drain and accept on the same edge.
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        fs        = 4'hB;
        op_a      = 8'h0F;
        op_b      = 8'hA0;
        push(8'hAF, 1'b0, 1'b0, "bp_or");
        @(negedge clk);
        chk("bp_same_cycle_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_new_result", 32'({out_valid, result}), 32'h1AF);

        // Reset in the middle of a long shift aborts it.
        issue(4'hD, 8'h07, 8'h01, 8'h00, 1'b0, 1'b0, -1, "abort");
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_rst_outputs", 32'({result, v, c, n, z, out_valid, busy}), 32'd0);
        chk("abort_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen += int'(out_valid);
        end
        chk("abort_no_output", 32'(seen), 32'd0);
        chk("abort_idle_ready", 32'(in_ready), 32'd1);

`ifdef FUNCTION_UNIT_STICKY_V_EN
        issue(4'h0, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 0, "st_ovf");
        issue(4'h0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 0, "st_noovf");
        @(negedge clk);
        chk("sticky_hold", 32'(v_sticky), 32'd1);
        @(posedge clk);
        #1 v_clr = 1'b1;
        @(posedge clk);
        #1 v_clr = 1'b0;
        @(negedge clk);
        chk("sticky_clear", 32'(v_sticky), 32'd0);
`endif

        for (int k = 0; k < 50 && sbq.size() != 0; k++) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
